// File: rtl/axi_fe_pkg.sv
// Shared types and constants for the AXI4-Lite slave front end.
// Contents: FSM state enum, arbitration grant enum, AXI response codes.
package axi_fe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CAP,
    RD_CAP,
    REQ,
    BRESP,
    RRESP
  } state_e;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_fe_timeout.sv
// Command watchdog for the AXI4-Lite front end.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : hold the count at zero (asserted whenever no command is active)
//   enable   : a command cycle elapsed without completion
//   expired  : enable is set on the LIMIT-th consecutive waiting cycle
module axi_fe_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axi4lite_slave_frontend.sv
// AXI4-Lite slave front end: arbitrates AXI reads/writes and issues one
// APB-style command at a time to the downstream transactor, then returns
// the completion as a B or R response.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   aw*/w*/b*             : AXI4-Lite write channels
//   ar*/r*                : AXI4-Lite read channels
//   cmd_sel..cmd_prot     : command toward the transactor, held until done
//   cmd_ready/slverr/rdata: single-cycle completion from the transactor
// Build option: define AXI_FE_TIMEOUT_EN to add a command watchdog that
// answers SLVERR after TIMEOUT_CYCLES cycles without completion.
// All outputs come straight from flops.
module axi4lite_slave_frontend
  import axi_fe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    cmd_sel,
  output logic                    cmd_write,
  output logic [ADDR_WIDTH-1:0]   cmd_addr,
  output logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic [2:0]              cmd_prot,
  input  logic                    cmd_ready,
  input  logic                    cmd_slverr,
  input  logic [DATA_WIDTH-1:0]   cmd_rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cmd_sel_q, cmd_sel_d, cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [STRB_W-1:0]     cmd_strb_q, cmd_strb_d;
  logic [2:0]            cmd_prot_q, cmd_prot_d;
  logic                  timeout_c;

`ifdef AXI_FE_TIMEOUT_EN
  // Count only while a command waits; cleared whenever REQ is not active.
  axi_fe_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != REQ),
    .enable  ((state_q == REQ) && !cmd_ready),
    .expired (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_strb_d   = cmd_strb_q;
    cmd_prot_d   = cmd_prot_q;

    case (state_q)
      IDLE: begin
        // On a tie the side opposite the last grant wins.
        if ((awvalid || wvalid) && (!arvalid || last_grant_q == GRANT_READ)) begin
          state_d      = WR_CAP;
          last_grant_d = GRANT_WRITE;
        end else if (arvalid) begin
          state_d      = RD_CAP;
          last_grant_d = GRANT_READ;
        end
      end
      WR_CAP: begin
        cmd_write_d = 1'b1;
        if (awvalid && awready_q) begin
          cmd_addr_d = awaddr;
          cmd_prot_d = awprot;
          aw_got_d   = 1'b1;
        end
        if (wvalid && wready_q) begin
          cmd_wdata_d = wdata;
          cmd_strb_d  = wstrb;
          w_got_d     = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          state_d  = REQ;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end
      RD_CAP: begin
        cmd_write_d = 1'b0;
        cmd_addr_d  = araddr;
        cmd_prot_d  = arprot;
        state_d     = REQ;
      end
      REQ: begin
        // A completion arriving on the expiry cycle takes priority.
        if (cmd_ready) begin
          if (cmd_write_q) begin
            bresp_d = cmd_slverr ? RESP_SLVERR : RESP_OKAY;
            state_d = BRESP;
          end else begin
            rresp_d = cmd_slverr ? RESP_SLVERR : RESP_OKAY;
            rdata_d = cmd_slverr ? '0 : cmd_rdata;
            state_d = RRESP;
          end
        end else if (timeout_c) begin
          if (cmd_write_q) begin
            bresp_d = RESP_SLVERR;
            state_d = BRESP;
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
            state_d = RRESP;
          end
        end
      end
      BRESP: begin
        if (bready) state_d = IDLE;
      end
      RRESP: begin
        if (rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    awready_d = (state_d == WR_CAP) && !aw_got_d;
    wready_d  = (state_d == WR_CAP) && !w_got_d;
    arready_d = (state_d == RD_CAP);
    cmd_sel_d = (state_d == REQ);
    bvalid_d  = (state_d == BRESP);
    rvalid_d  = (state_d == RRESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_READ;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      cmd_sel_q    <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_strb_q   <= '0;
      cmd_prot_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      cmd_sel_q    <= cmd_sel_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_strb_q   <= cmd_strb_d;
      cmd_prot_q   <= cmd_prot_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign cmd_sel   = cmd_sel_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cmd_strb  = cmd_strb_q;
  assign cmd_prot  = cmd_prot_q;

endmodule

// File: tb/tb_axi4lite_slave_frontend.sv
// Directed self-checking bench for axi4lite_slave_frontend.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// With AXI_FE_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8
// and the watchdog scenario is added.
module tb_axi4lite_slave_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        cmd_sel, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        cmd_ready, cmd_slverr;
  logic [31:0] cmd_rdata;

  int total = 0;
  int bad   = 0;

  axi4lite_slave_frontend #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awprot     (awprot),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bready     (bready),
    .bresp      (bresp),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arprot     (arprot),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .cmd_sel    (cmd_sel),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .cmd_prot   (cmd_prot),
    .cmd_ready  (cmd_ready),
    .cmd_slverr (cmd_slverr),
    .cmd_rdata  (cmd_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    cmd_ready = 0; cmd_slverr = 0; cmd_rdata = 0;
    tick(); tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_cmd_sel", 32'(cmd_sel), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cmd_addr", cmd_addr, 32'd0);
    rst = 1'b0;

    // Simple read
    arvalid = 1; araddr = 32'h10; arprot = 3'b001;
    tick();
    check("rd_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 0;
    check("rd_arready_drop", 32'(arready), 32'd0);
    check("rd_cmd_sel", 32'(cmd_sel), 32'd1);
    check("rd_cmd_addr", cmd_addr, 32'h10);
    check("rd_cmd_write", 32'(cmd_write), 32'd0);
    check("rd_cmd_prot", 32'(cmd_prot), 32'd1);
    tick();
    check("rd_cmd_sel_hold", 32'(cmd_sel), 32'd1);
    cmd_ready = 1; cmd_rdata = 32'hDEADBEEF;
    tick();
    cmd_ready = 0;
    check("rd_cmd_sel_drop", 32'(cmd_sel), 32'd0);
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_rresp", 32'(rresp), 32'd0);
    rready = 1;
    tick();
    rready = 0;
    check("rd_rvalid_done", 32'(rvalid), 32'd0);

    // Write, W before AW
    wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'b0011;
    tick();
    check("wr_wready", 32'(wready), 32'd1);
    tick();
    wvalid = 0;
    check("wr_wready_drop", 32'(wready), 32'd0);
    check("wr_awready_wait", 32'(awready), 32'd1);
    check("wr_no_sel_early", 32'(cmd_sel), 32'd0);
    tick();
    awvalid = 1; awaddr = 32'h20; awprot = 3'b010;
    tick();
    awvalid = 0;
    check("wr_cmd_sel", 32'(cmd_sel), 32'd1);
    check("wr_cmd_addr", cmd_addr, 32'h20);
    check("wr_cmd_strb", 32'(cmd_strb), 32'h3);
    check("wr_cmd_wdata", cmd_wdata, 32'hA5A5A5A5);
    check("wr_cmd_write", 32'(cmd_write), 32'd1);
    check("wr_cmd_prot", 32'(cmd_prot), 32'd2);
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    check("wr_cmd_sel_drop", 32'(cmd_sel), 32'd0);
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'd0);
    bready = 1;
    tick();
    bready = 0;
    check("wr_bvalid_done", 32'(bvalid), 32'd0);

    // Tie after reset: write first, with slave error
    rst = 1; tick(); rst = 0;
    awvalid = 1; awaddr = 32'h30; wvalid = 1; wdata = 32'h11111111; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h40; arprot = 3'b000;
    tick();
    check("tie1_awready", 32'(awready), 32'd1);
    check("tie1_arready", 32'(arready), 32'd0);
    tick();
    awvalid = 0; wvalid = 0;
    check("tie1_cmd_write", 32'(cmd_write), 32'd1);
    check("tie1_cmd_addr", cmd_addr, 32'h30);
    cmd_ready = 1; cmd_slverr = 1;
    tick();
    cmd_ready = 0; cmd_slverr = 0;
    check("wr_err_bresp", 32'(bresp), 32'd2);
    bready = 1;
    tick();
    bready = 0;
    tick();
    check("tie1_read_next", 32'(arready), 32'd1);
    tick();
    arvalid = 0;
    check("rd2_cmd_addr", cmd_addr, 32'h40);
    check("rd2_cmd_write", 32'(cmd_write), 32'd0);
    cmd_ready = 1; cmd_slverr = 1; cmd_rdata = 32'h12345678;
    tick();
    cmd_ready = 0; cmd_slverr = 0;
    check("rd_err_rresp", 32'(rresp), 32'd2);
    check("rd_err_rdata", rdata, 32'd0);

    // Backpressure on R; a new read must not be accepted
    arvalid = 1; araddr = 32'h50;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_arready", 32'(arready), 32'd0);
      tick();
    end
    check("bp_rresp_stable", 32'(rresp), 32'd2);
    awvalid = 1; wvalid = 1; awaddr = 32'h60;
    rready = 1;
    tick();
    rready = 0;
    check("bp_rvalid_done", 32'(rvalid), 32'd0);
    tick();
    check("tie2_awready", 32'(awready), 32'd1);
    check("tie2_arready", 32'(arready), 32'd0);
    tick();
    awvalid = 0; wvalid = 0;
    check("tie2_cmd_addr", cmd_addr, 32'h60);
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    check("tie2_bresp", 32'(bresp), 32'd0);
    bready = 1;
    tick();
    bready = 0;
    tick();
    tick();
    arvalid = 0;
    check("rst_req_cmd_sel", 32'(cmd_sel), 32'd1);
    check("rst_req_cmd_addr", cmd_addr, 32'h50);

    // Reset during REQ abandons the command
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_cmd_sel", 32'(cmd_sel), 32'd0);
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    check("stray_ready_rvalid", 32'(rvalid), 32'd0);
    check("stray_ready_bvalid", 32'(bvalid), 32'd0);
    check("stray_ready_sel", 32'(cmd_sel), 32'd0);

`ifdef AXI_FE_TIMEOUT_EN
    // Watchdog: no completion ever arrives
    awvalid = 1; wvalid = 1; awaddr = 32'h70;
    tick();
    tick();
    awvalid = 0; wvalid = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cmd_sel) break;
      n++;
      tick();
    end
    check("to_sel_cycles", 32'(n), 32'd8);
    check("to_bvalid", 32'(bvalid), 32'd1);
    check("to_bresp", 32'(bresp), 32'd2);
    bready = 1;
    tick();
    bready = 0;
    check("to_bvalid_done", 32'(bvalid), 32'd0);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_frontend.md
Name: axi4lite_slave_frontend

Overview:
- AXI4-Lite slave front end of the APB/AXI4-Lite bridge. Sits directly upstream of the APB transactor.
- Accepts AXI4-Lite read and write transactions and arbitrates between them.
- Issues one APB-style command at a time (sel/write/addr/wdata/strb/prot) to the transactor and holds it until completion.
- Returns completion as an AXI B or R response.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata; strobe width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 256, command watchdog limit; used only when AXI_FE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- awvalid/awready  in/out  1  write-address handshake.
- awaddr  in  ADDR_WIDTH.  awprot  in  3.
- wvalid/wready  in/out  1  write-data handshake.
- wdata  in  DATA_WIDTH.  wstrb  in  DATA_WIDTH/8.
- bvalid/bready  out/in  1.  bresp  out  2.
- arvalid/arready  in/out  1.  araddr  in  ADDR_WIDTH.  arprot  in  3.
- rvalid/rready  out/in  1.  rdata  out  DATA_WIDTH.  rresp  out  2.
- cmd_sel  out  1  command active toward the transactor.
- cmd_write  out  1.  cmd_addr  out  ADDR_WIDTH.  cmd_wdata  out  DATA_WIDTH.  cmd_strb  out  DATA_WIDTH/8.  cmd_prot  out  3.
- cmd_ready  in  1  single-cycle completion from the transactor.
- cmd_slverr  in  1.  cmd_rdata  in  DATA_WIDTH.  Both valid with cmd_ready.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; all ready/valid outputs 0; cmd_sel=0.
  - bresp=rresp=2'b00; rdata=0; cmd_* fields 0.
  - aw_got=w_got=0; last_grant=READ, so a write wins the first tie.
  - Reset mid-transaction abandons the command and the response; nothing is replayed.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- FSM states: IDLE, WR_CAP, RD_CAP, REQ, BRESP, RRESP.
- IDLE:
  - write_pend = awvalid|wvalid; read_pend = arvalid.
  - One pending -> go to it. Both pending -> grant the side opposite last_grant, then update last_grant.
  - Write -> WR_CAP; read -> RD_CAP.
- RD_CAP:
  - arready=1 for exactly this cycle; capture araddr/arprot; cmd_write=0; -> REQ.
- WR_CAP:
  - awready=!aw_got, wready=!w_got.
  - Capture awaddr/awprot on AW handshake, wdata/wstrb on W handshake, and set the matching flag.
  - AW and W may complete in any order or in the same cycle.
  - -> REQ in the cycle after both are captured; clear both flags on leaving. cmd_write=1.
- REQ:
  - cmd_sel=1; cmd_* held stable.
  - On cmd_ready: cmd_sel drops next cycle; latch resp = cmd_slverr ? 2'b10 : 2'b00.
  - Read: latch rdata = cmd_slverr ? 0 : cmd_rdata.
  - Then -> BRESP (write) or RRESP (read).
- BRESP: bvalid=1 and holds until bready; -> IDLE on handshake.
- RRESP: rvalid=1 and holds until rready; rdata/rresp stable; -> IDLE on handshake.
- Latency:
  - IDLE sees a request -> ready asserted next cycle.
  - Handshake -> cmd_sel the following cycle.
  - cmd_ready -> bvalid/rvalid the following cycle.
- Only one outstanding transaction; nothing else is accepted until the B/R handshake completes.
- cmd_ready outside REQ is ignored.
- Address, prot and strobe pass through unmodified (no alignment checks).

Optional Feature:
- Macro AXI_FE_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on REQ entry and increments each REQ cycle without cmd_ready.
  - At count TIMEOUT_CYCLES-1 with no cmd_ready: drop cmd_sel, respond SLVERR (2'b10) with rdata=0, go to BRESP/RRESP.
  - cmd_ready in the same cycle as expiry wins.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Package axi_fe_pkg:
  - state enum typedef.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - grant enum {GRANT_READ, GRANT_WRITE}.
- The watchdog is a natural sub-module: axi_fe_timeout (clear, enable, expired), instantiated only under the macro. Everything else stays in one module.

Test Plan:
- Read, simple: araddr=0x10, arprot=3'b001; cmd_ready one cycle after cmd_sel with cmd_rdata=0xDEADBEEF -> cmd_addr=0x10, cmd_write=0; rvalid with rdata=0xDEADBEEF, rresp=00.
- Write, W before AW: wdata=0xA5A5A5A5, wstrb=4'b0011 at t0; awaddr=0x20 at t3 -> one cmd_sel pulse-train with cmd_addr=0x20, cmd_strb=0011; bresp=00.
- Simultaneous AW/W/AR after reset -> write served first, then the read; next tie goes to the write again.
- Error: cmd_slverr=1 on a read -> rresp=10, rdata=0. On a write -> bresp=10.
- Backpressure and reset:
  - rready held low 5 cycles -> rvalid/rdata stable, arready stays 0 for a new arvalid.
  - rst=1 in REQ -> next cycle cmd_sel=0, state=IDLE, no rvalid.
- AXI_FE_TIMEOUT_EN with TIMEOUT_CYCLES=8, cmd_ready never asserted -> cmd_sel high exactly 8 cycles, then bresp=10.
